bcd_scan_ctrl: RTL and testbench

BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

---
 rtl/bcd_pkg.sv | 17 +
 rtl/scan_timer.sv | 38 +++
 rtl/bcd_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the multiplexed BCD display scanner.
// Holds the controller state encoding and the largest legal BCD code.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic is_bad(input logic [3:0] code);
      return code > BCD_MAX;
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit-slot timer: a down-counting prescaler paces the slot index, which
// walks 0..NDIG-1; frame_end marks the last prescaler tick of the last slot.
module scan_timer #(
   parameter int NDIG     = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   output logic [$clog2(NDIG)-1:0]  slot_idx,
   output logic                     frame_end
);

   localparam int SW = $clog2(NDIG);
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRE_LOAD  = PW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(NDIG - 1);

   // Remaining clocks in the current slot; reloading corresponds to prescaler 0.
   logic [PW-1:0] pre_cnt;
   logic          pre_tc;

   assign pre_tc    = (pre_cnt == '0);
   assign frame_end = run && pre_tc && (slot_idx == SLOT_LAST);

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         pre_cnt  <= PRE_LOAD;
         slot_idx <= '0;
      end else if (pre_tc) begin
         pre_cnt  <= PRE_LOAD;
         slot_idx <= (slot_idx == SLOT_LAST) ? '0 : slot_idx + 1'b1;
      end else begin
         pre_cnt  <= pre_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Multiplexed BCD display scanner: drives one digit at a time to a shared
// decoder, double-buffers new digit sets and swaps them on frame boundaries.
//
//   state | meaning
//   IDLE  | no data loaded, outputs blank
//   SCAN  | displaying the active set, ready for a new set
//   PEND  | new set held in shadow, waiting for the frame boundary
module bcd_scan_ctrl
   import bcd_pkg::*;
#(
   parameter int NDIG     = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [4*NDIG-1:0] load_data,
   output logic              load_ready,
   input  logic              lzb,
   output logic [3:0]        bcd_out,
   output logic [NDIG-1:0]   dig_sel,
   output logic              err
);

   localparam int SW = $clog2(NDIG);

   state_t            state;
   state_t            state_nxt;
   logic [4*NDIG-1:0] active;
   logic [4*NDIG-1:0] shadow;
   logic [4*NDIG-1:0] new_data;
   logic              new_set;
   logic              take_active;
   logic              take_shadow;
   logic              copy_shadow;
   logic              run;
   logic [SW-1:0]     slot_idx;
   logic              frame_end;
   logic [3:0]        cur_dig;
   logic              cur_bad;
   logic              upper_zero;
   logic              blank;
   logic [3:0]        bcd_nxt;
   logic [NDIG-1:0]   sel_nxt;

   function automatic logic has_bad(input logic [4*NDIG-1:0] set);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
         bad = bad | is_bad(set[4*k +: 4]);
      end
      return bad;
   endfunction

   assign run = (state != IDLE);

   scan_timer #(
      .NDIG     (NDIG),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan_timer (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .slot_idx  (slot_idx),
      .frame_end (frame_end)
   );

   always_comb begin
      state_nxt   = state;
      take_active = 1'b0;
      take_shadow = 1'b0;
      copy_shadow = 1'b0;
      load_ready  = (state != PEND);
      case (state)
         IDLE: begin
            if (load_valid) begin
               state_nxt   = SCAN;
               take_active = 1'b1;
            end
         end
         SCAN: begin
            if (load_valid) begin
               state_nxt   = PEND;
               take_shadow = 1'b1;
            end
         end
         PEND: begin
            if (frame_end) begin
               state_nxt   = SCAN;
               copy_shadow = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign new_set  = take_active || copy_shadow;
   assign new_data = copy_shadow ? shadow : load_data;

   // A zero digit is leading only if every more significant digit is zero too.
   always_comb begin
      cur_dig    = active[4*int'(slot_idx) +: 4];
      cur_bad    = is_bad(cur_dig);
      upper_zero = 1'b1;
      for (int k = 1; k < NDIG; k++) begin
         if (k > int'(slot_idx) && active[4*k +: 4] != 4'd0) begin
            upper_zero = 1'b0;
         end
      end
      blank   = cur_bad || (lzb && cur_dig == 4'd0 && slot_idx != '0 && upper_zero);
      bcd_nxt = 4'd0;
      sel_nxt = '0;
      if (run && !blank) begin
         bcd_nxt           = cur_dig;
         sel_nxt[slot_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         active  <= '0;
         shadow  <= '0;
         err     <= 1'b0;
         bcd_out <= 4'd0;
         dig_sel <= '0;
      end else begin
         state   <= state_nxt;
         bcd_out <= bcd_nxt;
         dig_sel <= sel_nxt;
         if (new_set) begin
            active <= new_data;
         end
         if (take_shadow) begin
            shadow <= load_data;
         end
         if (new_set && !has_bad(new_data)) begin
            err <= 1'b0;
         end else if (run && cur_bad) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl (NDIG=4, SCAN_DIV=4): expectations are
// queued per clock edge up front, a negedge monitor pops and compares them.
module tb_bcd_scan_ctrl;

   localparam int NDIG     = 4;
   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic        lzb;
   logic [3:0]  bcd_out;
   logic [3:0]  dig_sel;
   logic        err;

   bcd_scan_ctrl #(
      .NDIG     (NDIG),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .lzb        (lzb),
      .bcd_out    (bcd_out),
      .dig_sel    (dig_sel),
      .err        (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      int         cyc;
      logic [3:0] bcd;
      logic [3:0] sel;
      logic       err;
      logic       rdy;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   logic  drain_done = 1'b0;

   task automatic exp1(input int e, input logic [3:0] b, input logic [3:0] s,
                       input logic er, input logic r, input string nm);
      exp_q.push_back('{cyc: e, bcd: b, sel: s, err: er, rdy: r});
      name_q.push_back(nm);
   endtask

   task automatic exp_slot(input int e0, input logic [3:0] b, input logic [3:0] s,
                           input logic er, input logic r, input string nm);
      for (int i = 0; i < SCAN_DIV; i++) exp1(e0 + i, b, s, er, r, nm);
   endtask

   task automatic goto(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      exp_t  e;
      string nm;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         checks++;
         if (e.cyc != cyc || bcd_out !== e.bcd || dig_sel !== e.sel ||
             err !== e.err || load_ready !== e.rdy) begin
            errors++;
            $display("FAIL %s @cyc %0d (due %0d): got bcd=%0d sel=%b err=%b rdy=%b, want bcd=%0d sel=%b err=%b rdy=%b",
                     nm, cyc, e.cyc, bcd_out, dig_sel, err, load_ready, e.bcd, e.sel, e.err, e.rdy);
         end
      end
      if (drain_done) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 16'h0000;
      lzb        = 1'b0;

      // reset, then 0x4321 loaded from IDLE at edge 3
      exp1(1, 4'd0, 4'b0000, 1'b0, 1'b1, "reset1");
      exp1(2, 4'd0, 4'b0000, 1'b0, 1'b1, "reset2");
      exp1(3, 4'd0, 4'b0000, 1'b0, 1'b1, "load_latency");
      exp_slot(4,  4'd1, 4'b0001, 1'b0, 1'b1, "f1_s0");
      exp_slot(8,  4'd2, 4'b0010, 1'b0, 1'b1, "f1_s1");
      exp_slot(12, 4'd3, 4'b0100, 1'b0, 1'b1, "f1_s2");
      exp_slot(16, 4'd4, 4'b1000, 1'b0, 1'b1, "f1_s3");
      exp_slot(20, 4'd1, 4'b0001, 1'b0, 1'b1, "f2_s0_repeat");
      // 0x9999 loaded at slot 1 (edge 24); old set finishes, swap at edge 35
      exp_slot(24, 4'd2, 4'b0010, 1'b0, 1'b0, "pend_old_s1");
      exp_slot(28, 4'd3, 4'b0100, 1'b0, 1'b0, "pend_old_s2");
      for (int e = 32; e < 35; e++) exp1(e, 4'd4, 4'b1000, 1'b0, 1'b0, "pend_old_s3");
      exp1(35, 4'd4, 4'b1000, 1'b0, 1'b1, "boundary_ready");
      // 0x00A5 loaded at edge 36 (PEND), active from edge 51
      exp_slot(36, 4'd9, 4'b0001, 1'b0, 1'b0, "new_s0");
      exp1(40, 4'd9, 4'b0010, 1'b0, 1'b0, "new_s1");
      // 0x0005 loaded at edge 52, swap at edge 67
      exp_slot(52, 4'd5, 4'b0001, 1'b0, 1'b0, "a5_s0");
      exp_slot(56, 4'd0, 4'b0000, 1'b1, 1'b0, "a5_bad_slot");
      exp_slot(60, 4'd0, 4'b0100, 1'b1, 1'b0, "a5_err_hold_s2");
      for (int e = 64; e < 67; e++) exp1(e, 4'd0, 4'b1000, 1'b1, 1'b0, "a5_err_hold_s3");
      exp1(67, 4'd0, 4'b1000, 1'b0, 1'b1, "err_clear");
      // 0x0070 loaded at edge 68, lzb on from edge 72, swap at edge 83
      exp_slot(68, 4'd5, 4'b0001, 1'b0, 1'b0, "d5_s0");
      exp1(72, 4'd0, 4'b0000, 1'b0, 1'b0, "lzb_d5_s1");
      exp_slot(84, 4'd0, 4'b0001, 1'b0, 1'b1, "lzb_s0_kept");
      exp_slot(88, 4'd7, 4'b0010, 1'b0, 1'b1, "lzb_s1");
      exp_slot(92, 4'd0, 4'b0000, 1'b0, 1'b1, "lzb_s2_blank");
      exp_slot(96, 4'd0, 4'b0000, 1'b0, 1'b1, "lzb_s3_blank");
      // 0x1111 pending from edge 100; rst + load of 0x2222 at edge 104
      exp1(103, 4'd0, 4'b0001, 1'b0, 1'b0, "pend_again");
      exp1(104, 4'd0, 4'b0000, 1'b0, 1'b1, "rst_in_pend");
      for (int e = 105; e <= 120; e++) exp1(e, 4'd0, 4'b0000, 1'b0, 1'b1, "idle_no_shadow");
      // 0x0003 from IDLE at edge 121 (lzb still on)
      exp1(121, 4'd0, 4'b0000, 1'b0, 1'b1, "reload_latency");
      exp_slot(122, 4'd3, 4'b0001, 1'b0, 1'b1, "reload_s0");
      exp_slot(126, 4'd0, 4'b0000, 1'b0, 1'b1, "reload_s1_lzb");

      goto(2);
      rst = 1'b0; load_valid = 1'b1; load_data = 16'h4321;
      goto(3);
      load_valid = 1'b0;
      goto(23);
      load_valid = 1'b1; load_data = 16'h9999;
      goto(24);
      load_valid = 1'b0;
      goto(35);
      load_valid = 1'b1; load_data = 16'h00A5;
      goto(36);
      load_valid = 1'b0;
      goto(51);
      load_valid = 1'b1; load_data = 16'h0005;
      goto(52);
      load_valid = 1'b0;
      goto(67);
      load_valid = 1'b1; load_data = 16'h0070;
      goto(68);
      load_valid = 1'b0;
      goto(71);
      lzb = 1'b1;
      goto(99);
      load_valid = 1'b1; load_data = 16'h1111;
      goto(100);
      load_valid = 1'b0;
      goto(103);
      rst = 1'b1; load_valid = 1'b1; load_data = 16'h2222;
      goto(104);
      rst = 1'b0; load_valid = 1'b0;
      goto(120);
      load_valid = 1'b1; load_data = 16'h0003;
      goto(121);
      load_valid = 1'b0;
      goto(132);
      drain_done = 1'b1;
      goto(142);
      $display("FAIL watchdog: got no summary by cycle %0d, want summary", cyc);
      $fatal(1);
   end

endmodule
